// File: rtl/tdc_frame_rx.sv
// ---------------------------------------------------------------------------
// tdc_frame_rx : assembles up to four TDC depth/intensity beats into one
//                frame word and holds it for the host. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdc_frame_rx #(
   parameter int MAX_BEATS = 4,
   parameter int DW        = 15,
   parameter int IW        = 4
) (
   input  logic                    clk,
   input  logic                    rst_auto,
   input  logic [DW-1:0]           TDC_Odata,
   input  logic [IW-1:0]           TDC_Oint,
   input  logic [1:0]              TDC_Onum,
   input  logic                    TDC_Olast,
   input  logic                    TDC_Ovalid,
   output logic                    TDC_Oready,
   input  logic                    TDC_INT,
   output logic                    frm_valid,
   input  logic                    frm_ack,
   output logic [MAX_BEATS*DW-1:0] frm_data,
   output logic [MAX_BEATS*IW-1:0] frm_int,
   output logic [2:0]              frm_cnt,
   output logic [DW-1:0]           frm_min,
   output logic [5:0]              frm_isum,
   output logic                    frm_err,
   output logic [7:0]              frm_seq,
   output logic                    int_pend
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       ready_nxt;
   logic       accept;
   logic       release_frm;
   logic [1:0] num_l;
   logic       full;
   logic [2:0] cnt_nxt;
   logic       int_prev;

   assign accept  = TDC_Ovalid & TDC_Oready;
   assign full    = (frm_cnt == 3'd4);
   assign cnt_nxt = full ? frm_cnt : frm_cnt + 3'd1;

   always_ff @(posedge clk or negedge rst_auto) begin
      if (!rst_auto) begin
         state      <= IDLE;
         TDC_Oready <= 1'b0;
      end else begin
         state      <= state_nxt;
         TDC_Oready <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = TDC_Olast ? HOLD : COLLECT;
         COLLECT: if (accept && TDC_Olast) state_nxt = HOLD;
         HOLD:    if (frm_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is registered, so it is derived from the state we are heading into.
   always_comb begin
      frm_valid   = (state == HOLD);
      release_frm = (state == HOLD) && frm_ack;
      ready_nxt   = (state_nxt != HOLD);
   end

   always_ff @(posedge clk or negedge rst_auto) begin
      if (!rst_auto) begin
         frm_data <= '0;
         frm_int  <= '0;
         frm_cnt  <= 3'd0;
         frm_min  <= {DW{1'b1}};
         frm_isum <= 6'd0;
         frm_err  <= 1'b0;
         num_l    <= 2'd0;
      end else if (accept && state == IDLE) begin
         frm_data           <= '0;
         frm_data[DW-1:0]   <= TDC_Odata;
         frm_int            <= '0;
         frm_int[IW-1:0]    <= TDC_Oint;
         frm_cnt            <= 3'd1;
         frm_min            <= TDC_Odata;
         frm_isum           <= {{(6-IW){1'b0}}, TDC_Oint};
         num_l              <= TDC_Onum;
         frm_err            <= TDC_Olast && (TDC_Onum != 2'd0);
      end else if (accept && state == COLLECT) begin
         if (!full) begin
            for (int k = 0; k < MAX_BEATS; k++) begin
               if (frm_cnt == 3'(k)) begin
                  frm_data[k*DW +: DW] <= TDC_Odata;
                  frm_int[k*IW +: IW]  <= TDC_Oint;
               end
            end
            frm_cnt  <= cnt_nxt;
            frm_isum <= frm_isum + {{(6-IW){1'b0}}, TDC_Oint};
            if (TDC_Odata < frm_min) frm_min <= TDC_Odata;
         end
         // Dropped overflow beats do not count toward the final length check.
         frm_err <= frm_err | full | (TDC_Onum != num_l)
                    | (TDC_Olast && (cnt_nxt != ({1'b0, num_l} + 3'd1)));
      end
   end

   always_ff @(posedge clk or negedge rst_auto) begin
      if (!rst_auto) begin
         frm_seq  <= 8'd0;
         int_prev <= 1'b0;
         int_pend <= 1'b0;
      end else begin
         int_prev <= TDC_INT;
         if (release_frm) frm_seq <= frm_seq + 8'd1;
         if (TDC_INT && !int_prev) int_pend <= 1'b1;
         else if (release_frm)     int_pend <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tdc_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_tdc_frame_rx : directed self-checking bench for tdc_frame_rx. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tdc_frame_rx;

   logic        clk = 1'b0;
   logic        rst_auto;
   logic [14:0] TDC_Odata;
   logic [3:0]  TDC_Oint;
   logic [1:0]  TDC_Onum;
   logic        TDC_Olast;
   logic        TDC_Ovalid;
   logic        TDC_Oready;
   logic        TDC_INT;
   logic        frm_valid;
   logic        frm_ack;
   logic [59:0] frm_data;
   logic [15:0] frm_int;
   logic [2:0]  frm_cnt;
   logic [14:0] frm_min;
   logic [5:0]  frm_isum;
   logic        frm_err;
   logic [7:0]  frm_seq;
   logic        int_pend;

   int nvec = 0;
   int nerr = 0;

   tdc_frame_rx dut (
      .clk(clk), .rst_auto(rst_auto),
      .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum),
      .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid), .TDC_Oready(TDC_Oready),
      .TDC_INT(TDC_INT), .frm_valid(frm_valid), .frm_ack(frm_ack),
      .frm_data(frm_data), .frm_int(frm_int), .frm_cnt(frm_cnt),
      .frm_min(frm_min), .frm_isum(frm_isum), .frm_err(frm_err),
      .frm_seq(frm_seq), .int_pend(int_pend)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat once ready is high and returns #1 after the accepting edge.
   task automatic send_beat(input logic [14:0] d, input logic [3:0] i,
                            input logic [1:0] n, input logic l);
      int waited = 0;
      while (!TDC_Oready && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) check("ready_timeout", 64'(TDC_Oready), 64'd1);
      TDC_Odata  = d;
      TDC_Oint   = i;
      TDC_Onum   = n;
      TDC_Olast  = l;
      TDC_Ovalid = 1'b1;
      tick();
      TDC_Ovalid = 1'b0;
   endtask

   task automatic ack();
      frm_ack = 1'b1;
      tick();
      frm_ack = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(TDC_Oready), 64'd0);
      check({tag, "_valid"}, 64'(frm_valid), 64'd0);
      check({tag, "_data"},  64'(frm_data), 64'd0);
      check({tag, "_int"},   64'(frm_int), 64'd0);
      check({tag, "_cnt"},   64'(frm_cnt), 64'd0);
      check({tag, "_min"},   64'(frm_min), 64'h7FFF);
      check({tag, "_isum"},  64'(frm_isum), 64'd0);
      check({tag, "_err"},   64'(frm_err), 64'd0);
      check({tag, "_seq"},   64'(frm_seq), 64'd0);
      check({tag, "_ipend"}, 64'(int_pend), 64'd0);
   endtask

   initial begin
      rst_auto = 1'b0;
      TDC_Odata = '0; TDC_Oint = '0; TDC_Onum = '0; TDC_Olast = 1'b0;
      TDC_Ovalid = 1'b0; TDC_INT = 1'b0; frm_ack = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst");
      rst_auto = 1'b1;
      tick();
      check("rst_ready_rise", 64'(TDC_Oready), 64'd1);

      // Three-beat clean frame
      send_beat(15'd100, 4'd3, 2'd2, 1'b0);
      send_beat(15'd50,  4'd7, 2'd2, 1'b0);
      send_beat(15'd200, 4'd1, 2'd2, 1'b1);
      check("f1_valid", 64'(frm_valid), 64'd1);
      check("f1_ready", 64'(TDC_Oready), 64'd0);
      check("f1_cnt",   64'(frm_cnt), 64'd3);
      check("f1_min",   64'(frm_min), 64'd50);
      check("f1_isum",  64'(frm_isum), 64'd11);
      check("f1_err",   64'(frm_err), 64'd0);
      check("f1_slot3", 64'(frm_data[59:45]), 64'd0);
      check("f1_data",  64'(frm_data), (64'd200 << 30) | (64'd50 << 15) | 64'd100);
      check("f1_int",   64'(frm_int), 64'h0173);
      tick();
      tick();
      check("f1_ready_hold", 64'(TDC_Oready), 64'd0);
      ack();
      check("f1_seq",       64'(frm_seq), 64'd1);
      check("f1_rel_ready", 64'(TDC_Oready), 64'd1);
      check("f1_rel_valid", 64'(frm_valid), 64'd0);

      // Single-beat frame, upper slots must be cleared
      send_beat(15'h7FFC, 4'd15, 2'd0, 1'b1);
      check("f2_cnt",  64'(frm_cnt), 64'd1);
      check("f2_min",  64'(frm_min), 64'h7FFC);
      check("f2_isum", 64'(frm_isum), 64'd15);
      check("f2_err",  64'(frm_err), 64'd0);
      check("f2_data", 64'(frm_data), 64'h7FFC);
      ack();
      check("f2_seq",   64'(frm_seq), 64'd2);
      check("f2_ready", 64'(TDC_Oready), 64'd1);

      // Five beats: fifth dropped, overflow error
      send_beat(15'd10, 4'd1, 2'd3, 1'b0);
      send_beat(15'd20, 4'd1, 2'd3, 1'b0);
      send_beat(15'd5,  4'd1, 2'd3, 1'b0);
      send_beat(15'd30, 4'd1, 2'd3, 1'b0);
      check("f3_ready_full", 64'(TDC_Oready), 64'd1);
      send_beat(15'd1,  4'd1, 2'd3, 1'b1);
      check("f3_cnt",  64'(frm_cnt), 64'd4);
      check("f3_min",  64'(frm_min), 64'd5);
      check("f3_isum", 64'(frm_isum), 64'd4);
      check("f3_err",  64'(frm_err), 64'd1);
      check("f3_slot3", 64'(frm_data[59:45]), 64'd30);
      ack();

      // Short frame against announced count
      send_beat(15'd7, 4'd2, 2'd3, 1'b0);
      send_beat(15'd9, 4'd3, 2'd3, 1'b1);
      check("f4_cnt",  64'(frm_cnt), 64'd2);
      check("f4_err",  64'(frm_err), 64'd1);
      check("f4_isum", 64'(frm_isum), 64'd5);
      ack();

      // Beat count field changing mid-frame
      send_beat(15'd40, 4'd1, 2'd1, 1'b0);
      send_beat(15'd30, 4'd2, 2'd2, 1'b1);
      check("f5_cnt", 64'(frm_cnt), 64'd2);
      check("f5_err", 64'(frm_err), 64'd1);
      check("f5_min", 64'(frm_min), 64'd30);
      ack();

      // Beat presented during HOLD must wait and be taken exactly once
      send_beat(15'd555, 4'd4, 2'd0, 1'b1);
      TDC_Odata = 15'd777; TDC_Oint = 4'd6; TDC_Onum = 2'd0; TDC_Olast = 1'b1;
      TDC_Ovalid = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      check("f6_hold_ready", 64'(TDC_Oready), 64'd0);
      check("f6_hold_data",  64'(frm_data), 64'd555);
      check("f6_hold_seq",   64'(frm_seq), 64'd5);
      ack();
      check("f6_rel_valid", 64'(frm_valid), 64'd0);
      check("f6_rel_data",  64'(frm_data), 64'd555);
      tick();
      TDC_Ovalid = 1'b0;
      check("f6_acc_valid", 64'(frm_valid), 64'd1);
      check("f6_acc_data",  64'(frm_data), 64'd777);
      check("f6_acc_isum",  64'(frm_isum), 64'd6);
      ack();
      check("f6_seq", 64'(frm_seq), 64'd7);

      // Interrupt edge, then cleared by a frame release
      TDC_INT = 1'b1;
      tick();
      check("int_set", 64'(int_pend), 64'd1);
      send_beat(15'd3, 4'd3, 2'd0, 1'b1);
      check("int_hold", 64'(int_pend), 64'd1);
      ack();
      check("int_clr", 64'(int_pend), 64'd0);
      TDC_INT = 1'b0;
      tick();

      // Asynchronous reset in the middle of a frame
      send_beat(15'd11, 4'd1, 2'd2, 1'b0);
      check("mid_cnt", 64'(frm_cnt), 64'd1);
      #2;
      rst_auto = 1'b0;
      #1;
      check_reset_outputs("arst");
      tick();
      rst_auto = 1'b1;
      tick();

      // Sequence number wrap
      for (int f = 0; f < 256; f++) begin
         send_beat(15'(f), 4'd1, 2'd0, 1'b1);
         ack();
         if (f == 254) check("seq_255", 64'(frm_seq), 64'd255);
      end
      check("seq_wrap", 64'(frm_seq), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
